// File: rtl/pre_hash_pe_dispatcher_pkg.sv
// Shared types and constants for the hash PE dispatcher and its bank pickers.
package pre_hash_pe_dispatcher_pkg;

    localparam int DEF_HASH_ISSUE_WIDTH = 8;
    localparam int DEF_NUM_HASH_PE      = 8;
    localparam int DEF_ADDR_WIDTH       = 32;
    localparam int DEF_HASH_BITS        = 15;

    // Bank select bits and the row index left over; shared with the PE array and reorder side.
    localparam int HASH_BANK_BITS     = $clog2(DEF_NUM_HASH_PE);
    localparam int HASH_ROW_IDX_WIDTH = DEF_HASH_BITS - HASH_BANK_BITS;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DISPATCH = 1'b1
    } disp_state_e;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pre_hash_pe_dispatcher_picker.sv
// Per-bank priority picker: lowest-index pending position that hashes to this bank.
module hash_bank_picker
    import pre_hash_pe_dispatcher_pkg::*;
#(
    parameter int WIDTH = DEF_HASH_ISSUE_WIDTH,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] pending,
    input  logic [WIDTH-1:0] bank_match,
    output logic [WIDTH-1:0] pick_onehot,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_valid
);

    logic [WIDTH-1:0] candidates;

    // Scan from the top down so the lowest candidate is the last one written.
    always_comb begin
        candidates  = pending & bank_match;
        pick_onehot = '0;
        pick_idx    = '0;
        pick_valid  = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
                pick_idx       = IDX_W'(i);
                pick_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pre_hash_pe_dispatcher.sv
// Scatters one row of hashed positions onto the hash PEs, serialising bank conflicts into beats.
module pre_hash_pe_dispatcher
    import pre_hash_pe_dispatcher_pkg::*;
#(
    parameter int HASH_ISSUE_WIDTH = DEF_HASH_ISSUE_WIDTH,
    parameter int NUM_HASH_PE      = DEF_NUM_HASH_PE,
    parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
    parameter int HASH_BITS        = DEF_HASH_BITS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  input_valid,
    input  logic [ADDR_WIDTH-1:0]                 input_head_addr,
    input  logic [HASH_ISSUE_WIDTH-1:0]           input_row_valid,
    input  logic [HASH_ISSUE_WIDTH*HASH_BITS-1:0] input_hash_vec,
    input  logic                                  input_delim,
    input  logic [HASH_ISSUE_WIDTH*8-1:0]         input_data,
    output logic                                  input_ready,
    output logic                                  output_valid,
    output logic [NUM_HASH_PE-1:0]                output_mask,
    output logic [NUM_HASH_PE*ADDR_WIDTH-1:0]     output_addr_vec,
    output logic [NUM_HASH_PE*(HASH_BITS-$clog2(NUM_HASH_PE))-1:0] output_row_idx_vec,
    output logic [NUM_HASH_PE-1:0]                output_delim_vec,
    output logic [HASH_ISSUE_WIDTH*8-1:0]         output_data,
    input  logic                                  output_ready
);

    localparam int W         = HASH_ISSUE_WIDTH;
    localparam int P         = NUM_HASH_PE;
    localparam int BANK_BITS = $clog2(NUM_HASH_PE);
    localparam int ROW_IDX_W = HASH_BITS - BANK_BITS;
    localparam int POS_W     = idx_width(W);

    logic [ADDR_WIDTH-1:0]  head_addr_q, head_addr_d;
    logic [W*HASH_BITS-1:0] hash_vec_q, hash_vec_d;
    logic [W*8-1:0]         data_q, data_d;
    logic                   delim_q, delim_d;
    logic [POS_W-1:0]       last_pos_q, last_pos_d;
    logic [W-1:0]           pending_q, pending_d;
    disp_state_e            state_q, state_d;

    logic [HASH_BITS-1:0]   hash_arr [W];
    logic [W-1:0]           bank_match [P];
    logic [W-1:0]           pick_onehot [P];
    logic [POS_W-1:0]       pick_idx [P];
    logic [P-1:0]           pick_valid;
    logic [W-1:0]           picked_all;
    logic [POS_W-1:0]       row_last_pos;
    logic                   last_beat;
    logic                   beat_fire;
    logic                   row_accept;

    // Split the held hashes and work out which positions belong to each bank.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            hash_arr[i] = hash_vec_q[i*HASH_BITS +: HASH_BITS];
        end
        for (int b = 0; b < P; b++) begin
            bank_match[b] = '0;
            for (int i = 0; i < W; i++) begin
                bank_match[b][i] = (hash_arr[i][BANK_BITS-1:0] == BANK_BITS'(b));
            end
        end
    end

    for (genvar b = 0; b < P; b++) begin : g_picker
        hash_bank_picker #(
            .WIDTH (W),
            .IDX_W (POS_W)
        ) u_picker (
            .pending     (pending_q),
            .bank_match  (bank_match[b]),
            .pick_onehot (pick_onehot[b]),
            .pick_idx    (pick_idx[b]),
            .pick_valid  (pick_valid[b])
        );
    end

    // Handshake terms: the beat is the last one when its picks cover everything still pending.
    always_comb begin
        picked_all = '0;
        for (int b = 0; b < P; b++) begin
            picked_all = picked_all | pick_onehot[b];
        end
        last_beat  = (picked_all == pending_q);
        beat_fire  = output_valid && output_ready;
        row_accept = input_valid && input_ready;
    end

    // Highest valid position of an incoming row; only that position may carry the block delimiter.
    always_comb begin
        row_last_pos = '0;
        for (int i = 0; i < W; i++) begin
            if (input_row_valid[i]) begin
                row_last_pos = POS_W'(i);
            end
        end
    end

    // Next state: load a new row, or retire the positions sent on an accepted beat.
    always_comb begin
        head_addr_d = head_addr_q;
        hash_vec_d  = hash_vec_q;
        data_d      = data_q;
        delim_d     = delim_q;
        last_pos_d  = last_pos_q;
        pending_d   = pending_q;
        if (row_accept) begin
            head_addr_d = input_head_addr;
            hash_vec_d  = input_hash_vec;
            data_d      = input_data;
            delim_d     = input_delim;
            last_pos_d  = row_last_pos;
            pending_d   = input_row_valid;
        end else if (beat_fire) begin
            pending_d   = pending_q & ~picked_all;
        end
        state_d = (pending_d != '0) ? ST_DISPATCH : ST_IDLE;
    end

    // State and holding registers; reset drops any row that is mid-dispatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            head_addr_q <= '0;
            hash_vec_q  <= '0;
            data_q      <= '0;
            delim_q     <= 1'b0;
            last_pos_q  <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_addr_q <= head_addr_d;
            hash_vec_q  <= hash_vec_d;
            data_q      <= data_d;
            delim_q     <= delim_d;
            last_pos_q  <= last_pos_d;
            pending_q   <= pending_d;
        end
    end

    // Flow control: a new row may enter while idle or alongside the final beat of the current row.
    always_comb begin
        output_valid = (state_q == ST_DISPATCH);
        input_ready  = !rst && ((state_q == ST_IDLE) || (output_ready && last_beat));
    end

    // Beat contents per bank, built purely from the holding registers; unpicked banks read zero.
    always_comb begin
        output_mask        = '0;
        output_addr_vec    = '0;
        output_row_idx_vec = '0;
        output_delim_vec   = '0;
        for (int b = 0; b < P; b++) begin
            if (pick_valid[b]) begin
                output_mask[b]                                 = 1'b1;
                output_addr_vec[b*ADDR_WIDTH +: ADDR_WIDTH]    = head_addr_q + ADDR_WIDTH'(pick_idx[b]);
                output_row_idx_vec[b*ROW_IDX_W +: ROW_IDX_W]   = hash_arr[pick_idx[b]][HASH_BITS-1:BANK_BITS];
                output_delim_vec[b]                            = delim_q && (pick_idx[b] == last_pos_q);
            end
        end
    end

    assign output_data = data_q;

endmodule
